instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions: fetch FSM states, reset PC and NOP encoding.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Branch targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction memory request, presents
// fetched words to IF/ID, absorbs one decode stall in a skid entry and
// handles redirects, including draining an outstanding memory request.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request at pc outstanding, completions go to outputs or skid
// HOLD  | skid full and decode stalled, no request
// DRAIN | waiting out a request issued before a redirect; its data is dropped
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc4_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);

  if_state_e   r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_drain_addr, w_drain_addr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_skid_valid, w_skid_valid_nxt;
  logic [31:0] r_skid_pc4, w_skid_pc4_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_slot_free;

  assign w_pc_plus4  = r_pc + PC_STEP;
  assign w_slot_free = !r_valid || !stall;

  // The address of a drained request is frozen separately so pc can move on.
  assign imem_req  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign pc4_out   = r_pc4;
  assign instr_out = r_instr;
  assign valid_out = r_valid;

  // Next-state and datapath decisions; redirect overrides everything else.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_pc4_nxt        = r_pc4;
    w_instr_nxt      = r_instr;
    w_valid_nxt      = r_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_pc4_nxt   = r_skid_pc4;
    w_skid_instr_nxt = r_skid_instr;

    if (redirect) begin
      w_valid_nxt      = 1'b0;
      w_instr_nxt      = NOP;
      w_skid_valid_nxt = 1'b0;
      w_pc_nxt         = align_word(redirect_target);
      case (r_state)
        S_FETCH: begin
          if (!imem_ready) begin
            w_state_nxt      = S_DRAIN;
            w_drain_addr_nxt = r_pc;
          end
        end
        S_DRAIN: w_state_nxt = S_DRAIN;
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            w_pc_nxt = w_pc_plus4;
            if (w_slot_free) begin
              w_pc4_nxt   = w_pc_plus4;
              w_instr_nxt = imem_rdata;
              w_valid_nxt = 1'b1;
            end else begin
              w_skid_valid_nxt = 1'b1;
              w_skid_pc4_nxt   = w_pc_plus4;
              w_skid_instr_nxt = imem_rdata;
              w_state_nxt      = S_HOLD;
            end
          end else if (!stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_pc4_nxt        = r_skid_pc4;
            w_instr_nxt      = r_skid_instr;
            w_valid_nxt      = 1'b1;
            w_skid_valid_nxt = 1'b0;
            w_state_nxt      = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ready) w_state_nxt = S_FETCH;
          if (!stall) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, PC, output slot and skid registers; reset abandons any request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_pc4        <= '0;
      r_instr      <= NOP;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_pc4   <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_pc4        <= w_pc4_nxt;
      r_instr      <= w_instr_nxt;
      r_valid      <= w_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
      r_skid_instr <= w_skid_instr_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: program-order reference stream in a queue,
// random-latency memory model, random stall/redirect, plus directed scenarios.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] K      = 32'hA5A5_A5A5;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic        valid_out;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc4_out         (pc4_out),
    .instr_out       (instr_out),
    .valid_out       (valid_out)
  );

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] exp_next;
  int          checks = 0;
  int          failures = 0;
  int          consumed = 0;

  bit          mem_busy = 1'b0;
  int          wait_left = 0;
  int          wait_max = 0;
  int          force_wait = -1;

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Program order: consecutive words from the last restart address.
  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e.pc4   = exp_next + 32'd4;
      e.instr = exp_next ^ K;
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] a);
    exp_q.delete();
    exp_next = {a[31:2], 2'b00};
    refill();
  endfunction

  // One clock: memory model answers, then new stall/redirect are driven.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    if (reset && imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        if (force_wait >= 0) begin
          wait_left  = force_wait;
          force_wait = -1;
        end else begin
          wait_left = int'($urandom_range(wait_max, 0));
        end
      end
      if (wait_left == 0) begin
        imem_ready = 1'b1;
        imem_rdata = imem_addr ^ K;
        mem_busy   = 1'b0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      mem_busy   = 1'b0;
    end
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    if (rd) restart_stream(tgt);
    else refill();
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    mem_busy   = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    #1;
    chk("rst_req",   {31'b0, imem_req},  32'd0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc4",   pc4_out,   32'd0);
    restart_stream(RST_PC);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: consumes presented instructions against the expected stream.
  always @(negedge clk) begin
    if (!reset) begin
      prev_pend = 1'b0;
    end else begin
      if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (prev_pend) begin
        chk("req_held",    {31'b0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, prev_addr);
      end
      prev_pend = imem_req && !imem_ready;
      prev_addr = imem_addr;
      if (!valid_out) chk("nop_when_invalid", instr_out, NOP);
      if (valid_out && !stall && !redirect) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_underflow actual=%h required=none", pc4_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pc4_out",   pc4_out,   mon_e.pc4);
          chk("instr_out", instr_out, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #2;
    // Sequential fetch with zero-wait memory.
    wait_max = 0;
    apply_reset();
    cyc(1'b0, 1'b0, '0);
    chk("A_req0",  {31'b0, imem_req}, 32'd1);
    chk("A_addr0", imem_addr, RST_PC);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, '0);
      chk("A_addr",  imem_addr, RST_PC + 32'(4 * k));
      chk("A_pc4",   pc4_out,   RST_PC + 32'(4 * k));
      chk("A_valid", {31'b0, valid_out}, 32'd1);
    end

    // Three stalled cycles with a live output: skid fills, no request.
    cyc(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      cyc((k < 2) ? 1'b1 : 1'b0, 1'b0, '0);
      chk("B_req_hold",   {31'b0, imem_req},  32'd0);
      chk("B_valid_hold", {31'b0, valid_out}, 32'd1);
    end
    repeat (4) cyc(1'b0, 1'b0, '0);

    // Redirect against a slow outstanding request.
    apply_reset();
    force_wait = 4;
    cyc(1'b0, 1'b1, 32'h0040_0100);
    chk("C_addr_first", imem_addr, RST_PC);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, '0);
      chk("C_drain_req",  {31'b0, imem_req}, 32'd1);
      chk("C_drain_addr", imem_addr, RST_PC);
    end
    cyc(1'b0, 1'b0, '0);
    chk("C_new_addr", imem_addr, 32'h0040_0100);
    chk("C_valid",    {31'b0, valid_out}, 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("C_pc4", pc4_out, 32'h0040_0104);
    repeat (2) cyc(1'b0, 1'b0, '0);

    // Redirect and stall together, unaligned target.
    cyc(1'b1, 1'b1, 32'h0040_0203);
    cyc(1'b0, 1'b0, '0);
    chk("D_valid", {31'b0, valid_out}, 32'd0);
    chk("D_instr", instr_out, NOP);
    chk("D_addr",  imem_addr, 32'h0040_0200);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, '0);
    chk("E_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, '0);
    chk("E_pc4_wrap",  pc4_out,   32'h0000_0000);
    chk("E_addr_wrap", imem_addr, 32'h0000_0000);
    chk("E_instr",     instr_out, 32'hFFFF_FFFC ^ K);

    // Reset while in HOLD.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("F_hold_req", {31'b0, imem_req}, 32'd0);
    apply_reset();
    force_wait = 10;
    cyc(1'b0, 1'b0, '0);
    chk("F1_addr", imem_addr, RST_PC);
    chk("F1_req",  {31'b0, imem_req}, 32'd1);

    // Reset while in DRAIN.
    cyc(1'b0, 1'b1, 32'h0000_1000);
    cyc(1'b0, 1'b0, '0);
    chk("F2_drain_req",  {31'b0, imem_req}, 32'd1);
    chk("F2_drain_addr", imem_addr, RST_PC);
    apply_reset();
    cyc(1'b0, 1'b0, '0);
    chk("F2_addr", imem_addr, RST_PC);
    chk("F2_req",  {31'b0, imem_req}, 32'd1);

    // Random traffic.
    wait_max = 3;
    for (int n = 0; n < 4000; n++) begin
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      st  = ($urandom_range(99, 0) < 30);
      rd  = ($urandom_range(99, 0) < 4);
      tgt = ($urandom_range(1, 0) == 1) ? RST_PC + 32'($urandom_range(4095, 0)) : $urandom;
      if ($urandom_range(499, 0) == 0) apply_reset();
      else cyc(st, rd, tgt);
    end
    repeat (8) cyc(1'b0, 1'b0, '0);
    chk("R_progress", {31'b0, (consumed > 500)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
